// File: rtl/mult_iter.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned; result in z with a one-cycle ready pulse.
// Latency WIDTH+1 edges from accept to ready; start is ignored while busy, and back-to-back issue is allowed on ready.
module mult_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               clear,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] z
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic               neg;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    // The most negative value negates to itself, which is already its correct unsigned magnitude.
    a_mag  = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag  = (signed_mode && b[WIDTH-1]) ? -b : b;
    addend = mplier[0] ? mcand : '0;
    sum    = {1'b0, acc} + {1'b0, addend};
    prod   = {acc, mplier};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      ready  <= 1'b0;
      z      <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else if (clear) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            state  <= CALC;
            busy   <= 1'b1;
            ready  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b0;
          end
        end
        CALC: begin
          // Shift {carry, acc, mplier} right; the consumed multiplier bit drops off the bottom.
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          z     <= neg ? -prod : prod;
          state <= DONE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_iter.md
Name: mult_iter

Overview:
- Parametrised sequential multiplier for the CPU execute stage. Replaces the single-cycle MULTU-style unsigned multiply with one iterative radix-2 shift-add unit.
- Serves both signed (MULT) and unsigned (MULTU) instructions through a mode input.
- Uses a start/busy/ready handshake so the pipeline can stall on busy and capture the HI/LO result on ready.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits; legal values 4..64.
- CNT_W, 7, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request; sampled only in IDLE or DONE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched at accept.
- clear  in  1  synchronous abort; returns the unit to IDLE.
- a  in  WIDTH  multiplicand; latched at accept.
- b  in  WIDTH  multiplier; latched at accept.
- busy  out  1  high while an operation is in flight (CALC or SIGN).
- ready  out  1  one-cycle pulse: z is valid for the just-finished operation.
- z  out  2*WIDTH  product register; holds its value until the next completion or reset.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, ready=0, z=0, counter=0, internal registers=0. Reset overrides every other input and aborts any operation in progress.
- States: IDLE, CALC, SIGN, DONE. busy=1 exactly in CALC and SIGN; ready=1 exactly in DONE; both are registered state decodes.
- Accept: on a rising edge with state in {IDLE, DONE}, start=1 and clear=0, the unit:
  - latches |a| and |b| as WIDTH-bit magnitudes; in unsigned mode, or for a non-negative operand, the magnitude is the raw value;
  - sets neg = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
  - clears the 2*WIDTH accumulator and the counter, and enters CALC.
- Magnitude edge case: -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which is representable unsigned; no overflow special-case is needed.
- CALC: one iteration per clock. If the current multiplier LSB is 1, add the multiplicand, aligned to the upper half, into the accumulator. Then shift the combined {acc, multiplier} right by 1, keeping the adder carry. The counter increments each cycle; when it reaches WIDTH, go to SIGN.
- SIGN: z <= neg ? (~prod + 1) : prod, taken modulo 2^(2*WIDTH); go to DONE.
- DONE: ready=1 for exactly one cycle. Next state is CALC if a new start is accepted this edge, otherwise IDLE.
- Latency: ready rises on the (WIDTH+1)th rising edge after the accepting edge (33 for WIDTH=32). Back-to-back issue is possible by asserting start while ready=1.
- start while busy=1 is ignored, with no queueing; operand changes during CALC have no effect.
- clear=1 on any edge, reset deasserted: state=IDLE, busy=0, ready=0, z unchanged. clear has priority over start on the same edge.
- z changes only in SIGN, at reset, or never otherwise; it is stable through IDLE and DONE.
- All arithmetic is unsigned internally. Signed results equal the exact two's-complement 2*WIDTH-bit product.

Test Plan:
- Unsigned, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF, signed_mode=0 -> ready pulses 33 edges after accept; z=0xFFFFFFFE00000001; busy high for 33 cycles, then low.
- Signed: a=0xFFFFFFFD (-3), b=5 -> z=0xFFFFFFFFFFFFFFF1. Also a=0xFFFFFFFF, b=0xFFFFFFFF -> z=0x0000000000000001.
- Signed corner: a=b=0x80000000 -> z=0x4000000000000000. Unsigned with the same operands -> z=0x4000000000000000. a=0, b=0x12345678 -> z=0.
- Handshake: pulse start again at cycle 10 of an operation with different operands -> ignored, first result unaffected. Assert start during the ready cycle -> second result arrives 33 edges later, with no idle gap.
- Abort: assert clear at cycle 15 of an operation -> busy=0 next edge, ready never pulses, z keeps its previous value.
- Reset: drive reset=0 mid-CALC, asynchronously between clock edges -> busy, ready and z go to 0 immediately. After release, a fresh operation 7*6 -> z=42.
